ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, word-address width of the shared RAM (512 x 32-bit words).
REQ-002 Parameter MAX_BURST, default 8, maximum consecutive locked grants to one requester while the other waits; legal range 1..255.
REQ-003 clka  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 req0/req1  input  1 each  access request; requester n holds it and all its fields stable until gnt_n.
REQ-006 we0/we1  input  4 each  byte write enables, LSB = byte 0; all zero means read.
REQ-007 addr0/addr1  input  ADDR_WIDTH each  word address.
REQ-008 wdata0/wdata1  input  32 each  write data.
REQ-009 lock0/lock1  input  1 each  request to keep ownership on the next cycle (burst).
REQ-010 gnt0/gnt1  output  1 each  combinational; access issued to RAM this cycle.
REQ-011 rvalid0/rvalid1  output  1 each  registered; read data valid for requester n.
REQ-012 rdata  output  32  read data shared by both requesters; qualified by rvalid_n.
REQ-013 ram_addr  output  ADDR_WIDTH  RAM word address.
REQ-014 ram_din  output  32  RAM write data.
REQ-015 ram_wea  output  4  RAM per-byte write enable.
REQ-016 ram_dout  input  32  RAM read data, valid one cycle after the address is presented.

Function
REQ-017 At most one of gnt0/gnt1 is high in any cycle; gnt_n is never high while req_n is low.
REQ-018 Priority, evaluated each cycle: (a) lock hold: if last owner L has req_L & lock_L, and burst_cnt < MAX_BURST or the other requester is idle, grant L; (b) otherwise a sole requester wins; (c) if both request, grant the requester that is not last_grant.
REQ-019 Granted requester n: ram_addr = addr_n, ram_din = wdata_n, ram_wea = we_n, all in the same cycle.
REQ-020 No grant: ram_wea = 0, ram_addr = 0, ram_din = 0.
REQ-021 last_grant updates to n on every cycle gnt_n is high and holds otherwise.
REQ-022 burst_cnt: set to 1 when the grant goes to a requester different from last_grant; increments when the grant repeats to last_grant, saturating at MAX_BURST; holds when there is no grant.
REQ-023 When burst_cnt == MAX_BURST and the other requester is requesting, the lock is ignored and the other requester is granted.
REQ-024 Read (gnt_n & we_n == 0) in cycle T: rvalid_n high in T+1 only, with rdata = ram_dout; rvalid of the other requester is low.
REQ-025 Write grants never raise rvalid.
REQ-026 rdata = ram_dout, passed through combinationally.
REQ-027 Back-to-back grants are allowed; throughput is one access per cycle with no bubbles on owner switch.
REQ-028 Write then read of the same address on consecutive cycles: the read returns the newly written bytes.
REQ-029 Simultaneous read and write on the same cycle are impossible by construction: there is one grant per cycle.

Reset
REQ-030 With rst_n low at a clock edge: last_grant = 1 (requester 0 wins the first tie), burst_cnt = 0, rvalid0 = rvalid1 = 0.
REQ-031 Grant outputs and RAM outputs are forced inactive (gnt = 0, ram_wea = 0, ram_addr = 0, ram_din = 0) during every cycle rst_n is low.
REQ-032 A reset asserted in the cycle after a read grant suppresses that read's rvalid; no stale rvalid appears after reset releases.

Structure
REQ-033 Shared package ram_arb_pkg holds the requester-index constants (REQ0 = 0, REQ1 = 1), the default MAX_BURST and the byte-enable width (4).
REQ-034 Sub-module ram_arb_pick holds the combinational priority decision of REQ-018/REQ-023; it takes req, lock, last_grant and burst_cnt and produces a one-hot grant.
REQ-035 State is limited to last_grant, burst_cnt, the read-pending flag and the read-owner register.

Verification
REQ-036 Reset, then req0 = req1 = 1 with both reading, lock = 0 -> grants alternate 0,1,0,1; each rvalid goes to the correct side one cycle after its grant.
REQ-037 req0 writes 0xDEADBEEF to addr 5 with we = 4'b0011, then reads addr 5 (RAM pre-initialised to 0) -> rvalid0 with rdata = 0x0000BEEF.
REQ-038 MAX_BURST = 4, lock0 = 1, req0 and req1 held continuously -> 4 grants to requester 0, then 1 grant to requester 1, then 4 grants to requester 0.
REQ-039 lock1 = 1 with req0 idle for 20 cycles -> 20 consecutive gnt1, burst_cnt saturated at MAX_BURST; req0 rises -> gnt0 on the next arbitration.
REQ-040 Read granted at T, rst_n low at T+1 -> rvalid0 = rvalid1 = 0 through reset; first tie after release goes to requester 0.
REQ-041 Random req/we/lock traffic for 10k cycles against a scoreboard model -> gnt mutual exclusion holds every cycle, rvalid count equals read-grant count, and data matches the model.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared constants for the two-port RAM arbiter
package ram_arb_pkg;

    localparam int REQ0          = 0;
    localparam int REQ1          = 1;
    localparam int DEF_MAX_BURST = 8;
    localparam int BE_W          = 4;
    localparam int CNT_W         = 8;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational grant decision: lock hold, sole requester, then alternation
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic [1:0]       req,
    input  logic [1:0]       lock,
    input  logic             last_grant,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic [1:0]       gnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic other;
    logic hold;

    always_comb begin
        gnt   = 2'b00;
        other = ~last_grant;
        // A saturated burst yields only when the other side is actually waiting.
        hold  = req[last_grant] & lock[last_grant] &
                ((burst_cnt < MAX_CNT) | ~req[other]);
        if (hold) begin
            gnt[last_grant] = 1'b1;
        end else if (req == 2'b11) begin
            gnt[other] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester single-port RAM arbiter with burst lock and read return
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                  clka,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [BE_W-1:0]       we0,
    input  logic [BE_W-1:0]       we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [31:0]           wdata0,
    input  logic [31:0]           wdata1,
    input  logic                  lock0,
    input  logic                  lock1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [31:0]           rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    output logic [BE_W-1:0]       ram_wea,
    input  logic [31:0]           ram_dout
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;
    logic [1:0]       pick_gnt;
    logic [1:0]       gnt;

    ram_arb_pick #(
        .MAX_BURST(MAX_BURST)
    ) u_pick (
        .req        ({req1, req0}),
        .lock       ({lock1, lock0}),
        .last_grant (last_grant_q),
        .burst_cnt  (burst_cnt_q),
        .gnt        (pick_gnt)
    );

    assign gnt  = rst_n ? pick_gnt : 2'b00;
    assign gnt0 = gnt[REQ0];
    assign gnt1 = gnt[REQ1];

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_wea  = '0;
        if (gnt[REQ0]) begin
            ram_addr = addr0;
            ram_din  = wdata0;
            ram_wea  = we0;
        end else if (gnt[REQ1]) begin
            ram_addr = addr1;
            ram_din  = wdata1;
            ram_wea  = we1;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        rd_pend_d    = 1'b0;
        rd_owner_d   = rd_owner_q;
        if (gnt != 2'b00) begin
            last_grant_d = gnt[REQ1];
            rd_pend_d    = (ram_wea == '0);
            rd_owner_d   = gnt[REQ1];
            if (gnt[REQ1] == last_grant_q) begin
                burst_cnt_d = (burst_cnt_q >= MAX_CNT) ? MAX_CNT : burst_cnt_q + CNT_W'(1);
            end else begin
                burst_cnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            burst_cnt_q  <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Gating with rst_n kills a read return that lands in a reset cycle.
    assign rvalid0 = rst_n & rd_pend_q & ~rd_owner_q;
    assign rvalid1 = rst_n & rd_pend_q & rd_owner_q;
    assign rdata   = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with directed and random traffic
module tb_ram_arbiter;

    localparam int AW = 9;
    localparam int MB = 4;

    typedef struct {
        int          who;
        logic [31:0] data;
        int          cyc;
    } rd_t;

    logic          clka = 1'b0;
    logic          rst_n;
    logic          req0, req1, lock0, lock1;
    logic [3:0]    we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0]   rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_wea;

    logic [31:0] mem  [0:(1<<AW)-1];
    logic [31:0] mmem [0:(1<<AW)-1];

    rd_t q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  own = 1;
    int  run = 0;
    int  last_g = -1;
    int  dut_g = -1;
    int  rd_grants = 0;
    int  rvalids = 0;

    always #5 clka = ~clka;

    ram_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clka(clka), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wea(ram_wea),
        .ram_dout(ram_dout)
    );

    always @(posedge clka) begin
        ram_dout <= mem[ram_addr];
        for (int b = 0; b < 4; b++)
            if (ram_wea[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int model_pick();
        bit rq[2];
        bit lk[2];
        rq[0] = req0; rq[1] = req1; lk[0] = lock0; lk[1] = lock1;
        if (rq[own] && lk[own] && (run < MB || !rq[1-own])) return own;
        if (rq[0] && rq[1]) return 1 - own;
        if (rq[0]) return 0;
        if (rq[1]) return 1;
        return -1;
    endfunction

    task automatic step();
        int            g;
        logic [3:0]    w;
        logic [AW-1:0] a;
        logic [31:0]   d;
        #1;
        cyc++;
        dut_g = gnt1 ? 1 : (gnt0 ? 0 : -1);
        chk("gnt_mutex", 64'(gnt0 & gnt1), 64'(0));
        if (!rst_n) begin
            chk("reset_outputs", 64'({gnt0, gnt1, ram_wea, ram_addr, ram_din}), 64'(0));
            own = 1;
            run = 0;
            rd_grants -= q.size();
            q.delete();
            g = -1;
        end else begin
            g = model_pick();
            chk("grant", 64'({gnt1, gnt0}), (g == 1) ? 64'(2) : (g == 0) ? 64'(1) : 64'(0));
            if (g >= 0) begin
                w = g ? we1 : we0;
                a = g ? addr1 : addr0;
                d = g ? wdata1 : wdata0;
                chk("ram_port", 64'({ram_wea, ram_addr, ram_din}), 64'({w, a, d}));
                if (w == 4'b0000) begin
                    q.push_back('{who: g, data: mmem[a], cyc: cyc});
                    rd_grants++;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (w[b]) mmem[a][8*b +: 8] = d[8*b +: 8];
                end
                run = (g == own) ? ((run < MB) ? run + 1 : MB) : 1;
                own = g;
            end else begin
                chk("ram_idle", 64'({ram_wea, ram_addr, ram_din}), 64'(0));
            end
        end
        last_g = g;
        @(negedge clka);
    endtask

    initial begin
        rd_t e;
        forever begin
            @(negedge clka);
            #3;
            if (rvalid0 || rvalid1) begin
                rvalids++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rvalid_unexpected actual=%b%b required=00", rvalid1, rvalid0);
                end else begin
                    e = q.pop_front();
                    chk("rvalid_side", 64'({rvalid1, rvalid0}), (e.who == 1) ? 64'(2) : 64'(1));
                    chk("rdata", 64'(rdata), 64'(e.data));
                    chk("rvalid_latency", 64'(cyc), 64'(e.cyc + 1));
                end
            end else if (q.size() > 0 && q[0].cyc + 1 <= cyc) begin
                checks++;
                failures++;
                $display("FAIL rvalid_missing actual=0 required=1 grant_cycle=%0d", q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    initial begin
        int pat036[4];
        int pat038[9];
        pat036 = '{0, 1, 0, 1};
        pat038 = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]  = 32'h0;
            mmem[i] = 32'h0;
        end
        rst_n = 0;
        idle_inputs();
        @(negedge clka);
        for (int i = 0; i < 3; i++) step();
        chk("reset_rvalid", 64'({rvalid1, rvalid0}), 64'(0));
        chk("reset_burst_cnt", 64'(dut.burst_cnt_q), 64'(0));

        // alternating reads
        rst_n = 1;
        req0 = 1; req1 = 1; addr0 = 1; addr1 = 2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("alternate_grant", 64'(dut_g), 64'(pat036[i]));
        end
        idle_inputs();
        step();

        // partial-byte write then read back
        req0 = 1; we0 = 4'b0011; addr0 = 5; wdata0 = 32'hDEADBEEF;
        step();
        we0 = 4'b0000;
        step();
        req0 = 0;
        chk("write_read_rvalid0", 64'({rvalid1, rvalid0}), 64'(1));
        chk("write_read_rdata", 64'(rdata), 64'(32'h0000BEEF));
        step();

        // burst limit with lock0
        rst_n = 0;
        step();
        rst_n = 1;
        req0 = 1; req1 = 1; lock0 = 1; addr0 = 7; addr1 = 8;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("burst_pattern", 64'(dut_g), 64'(pat038[i]));
        end

        // long lock1 burst with requester 0 idle
        req0 = 0; lock0 = 0; lock1 = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("lock1_run", 64'(dut_g), 64'(1));
        end
        chk("burst_saturated", 64'(dut.burst_cnt_q), 64'(MB));
        req0 = 1;
        step();
        chk("saturated_yield", 64'(dut_g), 64'(0));
        idle_inputs();
        step();

        // reset right after a read grant
        req0 = 1; addr0 = 5;
        step();
        req0 = 0;
        rst_n = 0;
        #1;
        chk("reset_kills_rvalid", 64'({rvalid1, rvalid0}), 64'(0));
        step();
        chk("reset_hold_rvalid", 64'({rvalid1, rvalid0}), 64'(0));
        rst_n = 1;
        req0 = 1; req1 = 1;
        step();
        chk("tie_after_reset", 64'(dut_g), 64'(0));
        idle_inputs();
        step();

        // random traffic
        for (int n = 0; n < 10000; n++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            if (!req0 || last_g == 0) begin
                req0   = ($urandom_range(0, 9) < 6);
                we0    = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
                addr0  = AW'($urandom_range(0, 15));
                wdata0 = $urandom;
                lock0  = ($urandom_range(0, 3) == 0);
            end
            if (!req1 || last_g == 1) begin
                req1   = ($urandom_range(0, 9) < 6);
                we1    = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
                addr1  = AW'($urandom_range(0, 15));
                wdata1 = $urandom;
                lock1  = ($urandom_range(0, 3) == 0);
            end
            step();
        end
        rst_n = 1;
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
        chk("rvalid_count", 64'(rvalids), 64'(rd_grants));
        chk("scoreboard_empty", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
